// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: shifts {pad0, pad1} out MSB first on pmod_clk/pmod_data,
// then pulses pmod_latch. Absent pads are sent as all-ones.

module gamepad_pmod_tx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned FRAME_GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] pad0_buttons,
    input  logic        pad0_present,
    input  logic [11:0] pad1_buttons,
    input  logic        pad1_present,
    output logic        pmod_clk,
    output logic        pmod_data,
    output logic        pmod_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CntMax = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(FRAME_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [23:0]     sr_q, sr_d;
    logic            pclk_q, pclk_d;
    logic            data_q, data_d;
    logic            latch_q, latch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [23:0]     word;
    logic            start;

    assign word = {pad0_present ? pad0_buttons : 12'hFFF,
                   pad1_present ? pad1_buttons : 12'hFFF};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        pclk_d  = pclk_q;
        data_d  = data_q;
        latch_d = 1'b0;
        done_d  = 1'b0;
        start   = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) begin
                    start = 1'b1;
                end
            end
            StShiftLo: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    pclk_d  = 1'b1;
                    state_d = StShiftHi;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShiftHi: begin
                if (cnt_q == DivLast) begin
                    cnt_d  = '0;
                    pclk_d = 1'b0;
                    if (bit_q == 5'd23) begin
                        data_d  = 1'b0;
                        latch_d = 1'b1;
                        state_d = StLatch;
                    end else begin
                        // sr_q holds the not-yet-sent bits left-aligned
                        bit_d   = bit_q + 5'd1;
                        data_d  = sr_q[23];
                        sr_d    = {sr_q[22:0], 1'b0};
                        state_d = StShiftLo;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLatch: begin
                if (cnt_q == DivLast) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (FRAME_GAP == 0) begin
                        if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    latch_d = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pclk_d  = 1'b0;
                data_d  = 1'b0;
            end
        endcase

        if (start) begin
            state_d = StShiftLo;
            cnt_d   = '0;
            bit_d   = '0;
            pclk_d  = 1'b0;
            data_d  = word[23];
            sr_d    = {word[22:0], 1'b0};
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            pclk_q  <= 1'b0;
            data_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            pclk_q  <= pclk_d;
            data_q  <= data_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pmod_clk   = pclk_q;
    assign pmod_data  = data_q;
    assign pmod_latch = latch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: a sampling receiver model plus cycle-exact waveform checks
// on a default instance (CLK_DIV=2, FRAME_GAP=16) and a fast one (CLK_DIV=1, FRAME_GAP=0).

module tb_gamepad_pmod_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        en_a = 1'b0, en_b = 1'b0;
    logic [11:0] pad0_a = '0, pad1_a = '0, pad0_b = '0, pad1_b = '0;
    logic        pad0p_a = 1'b0, pad1p_a = 1'b0, pad0p_b = 1'b0, pad1p_b = 1'b0;
    logic        pclk_a, pdata_a, plat_a, busy_a, done_a;
    logic        pclk_b, pdata_b, plat_b, busy_b, done_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gamepad_pmod_tx #(.CLK_DIV(2), .FRAME_GAP(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a),
        .pad0_buttons(pad0_a), .pad0_present(pad0p_a),
        .pad1_buttons(pad1_a), .pad1_present(pad1p_a),
        .pmod_clk(pclk_a), .pmod_data(pdata_a), .pmod_latch(plat_a),
        .busy(busy_a), .frame_done(done_a)
    );

    gamepad_pmod_tx #(.CLK_DIV(1), .FRAME_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b),
        .pad0_buttons(pad0_b), .pad0_present(pad0p_b),
        .pad1_buttons(pad1_b), .pad1_present(pad1p_b),
        .pmod_clk(pclk_b), .pmod_data(pdata_b), .pmod_latch(plat_b),
        .busy(busy_b), .frame_done(done_b)
    );

    // Receiver models: shift on pmod_clk rise, copy on pmod_latch rise
    logic        pclk_a_prev = 1'b0, plat_a_prev = 1'b0, pclk_b_prev = 1'b0, plat_b_prev = 1'b0;
    logic [23:0] rsr_a = '0, rword_a = '0, rsr_b = '0, rword_b = '0;
    int          rise_a = 0, lcnt_a = 0, dcnt_a = 0, rise_b = 0, lcnt_b = 0, dcnt_b = 0;

    always @(negedge clk) begin
        pclk_a_prev <= pclk_a;
        plat_a_prev <= plat_a;
        if (pclk_a && !pclk_a_prev) begin
            rsr_a  <= {rsr_a[22:0], pdata_a};
            rise_a <= rise_a + 1;
        end
        if (plat_a && !plat_a_prev) begin
            rword_a <= rsr_a;
            lcnt_a  <= lcnt_a + 1;
        end
        if (done_a) dcnt_a <= dcnt_a + 1;
    end

    always @(negedge clk) begin
        pclk_b_prev <= pclk_b;
        plat_b_prev <= plat_b;
        if (pclk_b && !pclk_b_prev) begin
            rsr_b  <= {rsr_b[22:0], pdata_b};
            rise_b <= rise_b + 1;
        end
        if (plat_b && !plat_b_prev) begin
            rword_b <= rsr_b;
            lcnt_b  <= lcnt_b + 1;
        end
        if (done_b) dcnt_b <= dcnt_b + 1;
    end

    typedef struct packed {
        logic [11:0] p0;
        logic        p0p;
        logic [11:0] p1;
        logic        p1p;
        logic [23:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected waveform derived from the frame timing formulas, enable held high
    task automatic check_timing(input int inst, input int cd, input int fg,
                                input logic [23:0] w, input int ncyc);
        int p, cp;
        logic [4:0] act, exp;
        p = 49 * cd + fg;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            cp = c % p;
            exp[4] = (cp < 48 * cd) && (((cp / cd) % 2) == 1);
            exp[3] = (cp < 48 * cd) ? w[23 - cp / (2 * cd)] : 1'b0;
            exp[2] = (cp >= 48 * cd) && (cp < 49 * cd);
            exp[1] = (c >= 49 * cd) && (((c - 49 * cd) % p) == 0);
            exp[0] = 1'b1;
            act = (inst == 0) ? {pclk_a, pdata_a, plat_a, done_a, busy_a}
                              : {pclk_b, pdata_b, plat_b, done_b, busy_b};
            check($sformatf("timing%0d_c%0d", inst, c), 32'(act), 32'(exp));
        end
    endtask

    task automatic wait_idle_a(input string name);
        for (int i = 0; i < 400 && busy_a; i++) tick();
        check({name, "_idle_timeout"}, 32'(busy_a), 32'd0);
    endtask

    // One frame on instance A; enable is dropped after drop_at rising edges
    task automatic run_frame(input logic [11:0] p0, input logic p0p,
                             input logic [11:0] p1, input logic p1p, input int drop_at,
                             output logic [23:0] word, output int edges,
                             output int latches, output int dones);
        int e0, l0, d0;
        pad0_a = p0; pad0p_a = p0p; pad1_a = p1; pad1p_a = p1p;
        e0 = rise_a; l0 = lcnt_a; d0 = dcnt_a;
        en_a = 1'b1;
        tick();
        for (int i = 0; i < 400 && (rise_a - e0) < drop_at; i++) tick();
        en_a = 1'b0;
        wait_idle_a("run_frame");
        word = rword_a; edges = rise_a - e0; latches = lcnt_a - l0; dones = dcnt_a - d0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [23:0] word;
        int edges, latches, dones, e0, l0, d0;

        vecs[0] = '{p0: 12'h801, p0p: 1'b1, p1: 12'h000, p1p: 1'b0, exp_word: 24'h801FFF};
        vecs[1] = '{p0: 12'h000, p0p: 1'b1, p1: 12'h000, p1p: 1'b1, exp_word: 24'h000000};
        vecs[2] = '{p0: 12'hABC, p0p: 1'b1, p1: 12'h123, p1p: 1'b1, exp_word: 24'hABC123};
        vecs[3] = '{p0: 12'h555, p0p: 1'b0, p1: 12'hAAA, p1p: 1'b1, exp_word: 24'hFFFAAA};
        vecs[4] = '{p0: 12'hFFF, p0p: 1'b1, p1: 12'h5A5, p1p: 1'b0, exp_word: 24'hFFFFFF};
        vecs[5] = '{p0: 12'h3C3, p0p: 1'b1, p1: 12'hF0F, p1p: 1'b1, exp_word: 24'h3C3F0F};

        // Reset with enable already high; outputs must stay 0 while held
        #3 rst_n = 1'b0;
        pad0_a = 12'h801; pad0p_a = 1'b1; pad1_a = 12'h000; pad1p_a = 1'b0;
        en_a = 1'b1;
        tick(); tick();
        check("reset_a", 32'({pclk_a, pdata_a, plat_a, busy_a, done_a}), 32'd0);
        check("reset_b", 32'({pclk_b, pdata_b, plat_b, busy_b, done_b}), 32'd0);

        // Release: edge 0 starts the frame; two full frames back to back
        rst_n = 1'b1;
        check_timing(0, 2, 16, 24'h801FFF, 228);
        check("loopback_word", 32'(rword_a), 32'h801FFF);
        check("decode_b", 32'(rword_a[23]), 32'd1);
        check("decode_r", 32'(rword_a[12]), 32'd1);
        check("decode_pad1_present", 32'(rword_a[11:0] != 12'hFFF), 32'd0);
        en_a = 1'b0;
        wait_idle_a("t1");

        // Enable pulsed between clock edges in IDLE starts nothing
        e0 = rise_a;
        en_a = 1'b1;
        #2 en_a = 1'b0;
        tick(); tick();
        check("idle_glitch_busy", 32'(busy_a), 32'd0);
        check("idle_glitch_edges", 32'(rise_a - e0), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].p0, vecs[v].p0p, vecs[v].p1, vecs[v].p1p, 0,
                      word, edges, latches, dones);
            check($sformatf("vec%0d_word", v), 32'(word), 32'(vecs[v].exp_word));
            check($sformatf("vec%0d_edges", v), 32'(edges), 32'd24);
            check($sformatf("vec%0d_latches", v), 32'(latches), 32'd1);
            check($sformatf("vec%0d_dones", v), 32'(dones), 32'd1);
        end

        // Inputs change at bit 5: current frame keeps the old snapshot
        pad0_a = 12'h000; pad0p_a = 1'b1; pad1_a = 12'h000; pad1p_a = 1'b1;
        e0 = rise_a; d0 = dcnt_a;
        en_a = 1'b1;
        tick();
        for (int i = 0; i < 400 && (rise_a - e0) < 5; i++) tick();
        pad0_a = 12'hABC;
        for (int i = 0; i < 400 && (dcnt_a - d0) < 1; i++) tick();
        check("midchange_first", 32'(rword_a), 32'h000000);
        for (int i = 0; i < 400 && (rise_a - e0) < 25; i++) tick();
        en_a = 1'b0;
        wait_idle_a("t3");
        check("midchange_second", 32'(rword_a), 32'hABC000);
        check("midchange_dones", 32'(dcnt_a - d0), 32'd2);
        check("midchange_edges", 32'(rise_a - e0), 32'd48);

        // Enable dropped at bit 10: frame still completes, then stays idle
        run_frame(12'h6E1, 1'b1, 12'h09D, 1'b1, 10, word, edges, latches, dones);
        check("drop_word", 32'(word), 32'h6E109D);
        check("drop_edges", 32'(edges), 32'd24);
        check("drop_latches", 32'(latches), 32'd1);
        check("drop_dones", 32'(dones), 32'd1);
        e0 = rise_a;
        for (int i = 0; i < 20; i++) tick();
        check("drop_stays_idle", 32'({busy_a, rise_a - e0 == 0}), 32'b01);

        // Async reset during SHIFT_HI of bit 12 aborts the frame
        pad0_a = 12'h5A5; pad0p_a = 1'b1; pad1_a = 12'hC3C; pad1p_a = 1'b1;
        e0 = rise_a; l0 = lcnt_a; d0 = dcnt_a;
        en_a = 1'b1;
        tick();
        for (int i = 0; i < 400 && (rise_a - e0) < 13; i++) tick();
        check("abort_in_shift_hi", 32'(pclk_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_zero", 32'({pclk_a, pdata_a, plat_a, busy_a, done_a}), 32'd0);
        en_a = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("abort_no_latch", 32'(lcnt_a - l0), 32'd0);
        check("abort_no_done", 32'(dcnt_a - d0), 32'd0);
        run_frame(12'h5A5, 1'b1, 12'hC3C, 1'b1, 0, word, edges, latches, dones);
        check("after_abort_word", 32'(word), 32'h5A5C3C);
        check("after_abort_edges", 32'(edges), 32'd24);

        // Fast instance: back-to-back frames, period 49
        pad0_b = 12'h5A5; pad0p_b = 1'b1; pad1_b = 12'h777; pad1p_b = 1'b0;
        e0 = rise_b; l0 = lcnt_b; d0 = dcnt_b;
        en_b = 1'b1;
        check_timing(1, 1, 0, 24'h5A5FFF, 99);
        check("fast_edges", 32'(rise_b - e0), 32'd48);
        check("fast_latches", 32'(lcnt_b - l0), 32'd2);
        check("fast_dones", 32'(dcnt_b - d0), 32'd2);
        check("fast_word", 32'(rword_b), 32'h5A5FFF);
        en_b = 1'b0;
        for (int i = 0; i < 200 && busy_b; i++) tick();
        check("fast_idle_timeout", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
